psw_store: RTL and testbench
============================

PSW_STORE -- requirements
Module: psw_store

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 8, meaning the capacity of the memory and of the buffer in digits.
REQ-002 SHALL have parameter MIN_DIGITS, default 4, meaning the minimum stored length for which same_o may assert.
REQ-003 SHALL have parameter MASTER_LEN, default 8, meaning the master code length in digits (1..MAX_DIGITS).
REQ-004 SHALL have parameter MASTER_CODE, default 32'h1234_5678, meaning the master code as packed 4-bit BCD, last-entered digit in bits [3:0].
REQ-005 clk_i  input  1  sole clock; all state updates on posedge.
REQ-006 reset_i  input  1  reset, synchronous and active-high.
REQ-007 digit_i  input  4  BCD digit captured on a shift.
REQ-008 mem_rst_i  input  1  clear the password memory.
REQ-009 mem_sl_i  input  1  shift digit_i into the password memory.
REQ-010 buff_rst_i  input  1  clear the entry buffer.
REQ-011 buff_sl_i  input  1  shift digit_i into the entry buffer.
REQ-012 same_o  output  1  buffer equals stored password.
REQ-013 master_same_o  output  1  buffer equals master code.
REQ-014 mem_limit_o  output  1  memory holds MAX_DIGITS digits.
REQ-015 buff_limit_o  output  1  buffer holds MAX_DIGITS digits.
REQ-016 mem_len_o  output  4  digits held in memory.
REQ-017 buff_len_o  output  4  digits held in buffer.

Function
REQ-018 SHALL hold mem_data (4*MAX_DIGITS bits), mem_len, buff_data and buff_len as registers updated only on posedge clk_i.
REQ-019 On a shift, the store SHALL update its data as data <= {data[4*MAX_DIGITS-5:0], digit_i} and increment its length by 1.
REQ-020 SHALL ignore a shift (no data change, no length change) when digit_i > 9 or the target length equals MAX_DIGITS.
REQ-021 When rst and sl are asserted in the same cycle for one store, the store SHALL give rst priority: data and length go to 0 and the digit is dropped.
REQ-022 SHALL operate memory and buffer independently; simultaneous mem and buff commands in the same cycle SHALL both take effect.
REQ-023 rst and sl are level commands; every cycle in which a command is high SHALL act once (one shift per asserted cycle).
REQ-024 mem_limit_o SHALL equal (mem_len == MAX_DIGITS), and buff_limit_o SHALL equal (buff_len == MAX_DIGITS); both are combinational from registers.
REQ-025 same_o SHALL be 1 iff all of the following hold: mem_len == buff_len, mem_len >= MIN_DIGITS, and mem_data == buff_data (full width; unused upper nibbles are 0 by construction).
REQ-026 master_same_o SHALL be 1 iff buff_len == MASTER_LEN and the lower 4*MASTER_LEN bits of buff_data equal MASTER_CODE.
REQ-027 same_o and master_same_o SHALL be derived combinationally from registers only; they change one posedge after the causing command, with no dependence on digit_i.
REQ-028 SHALL hold the register value whenever no command is asserted.

Reset
REQ-029 While reset_i is high at a posedge, the block SHALL clear all data and lengths to 0, overriding all commands.
REQ-030 After reset, outputs SHALL be: same_o=0, master_same_o=0, mem_limit_o=0, buff_limit_o=0, mem_len_o=0, buff_len_o=0.
REQ-031 Reset asserted mid-entry SHALL discard partial contents; no state survives reset.

Verification
REQ-032 Memory entry 1,2,3,4 and buffer entry 1,2,3,4 -> same_o=1, mem_len_o=buff_len_o=4; one extra buffer shift of 5 -> same_o=0 on the next cycle.
REQ-033 Memory entry 1,2,3 and buffer entry 1,2,3 -> same_o=0 (below MIN_DIGITS).
REQ-034 Nine memory shifts of 9 -> mem_len_o=8, mem_limit_o=1, data=32'h9999_9999; the ninth shift is ignored.
REQ-035 Buffer entry 1..8 -> master_same_o=1; buff_rst_i and buff_sl_i asserted together -> buff_len_o=0, master_same_o=0.
REQ-036 digit_i=4'hA with mem_sl_i -> no change; reset_i asserted with mem_sl_i mid-entry -> all outputs 0 on the next cycle.
REQ-037 mem_sl_i and buff_sl_i asserted together with digit_i=7 -> both lengths increment to 1, and both stores hold 7.

Source files
------------

// File: rtl/psw_store.sv
// Password store: a password memory and an entry buffer, each a BCD shift register
// with a digit count, plus comparison flags against each other and a master code.
module psw_store #(
    parameter int                      MAX_DIGITS  = 8,
    parameter int                      MIN_DIGITS  = 4,
    parameter int                      MASTER_LEN  = 8,
    parameter logic [4*MAX_DIGITS-1:0] MASTER_CODE = 32'h1234_5678
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] digit_i,
    input  logic       mem_rst_i,
    input  logic       mem_sl_i,
    input  logic       buff_rst_i,
    input  logic       buff_sl_i,
    output logic       same_o,
    output logic       master_same_o,
    output logic       mem_limit_o,
    output logic       buff_limit_o,
    output logic [3:0] mem_len_o,
    output logic [3:0] buff_len_o
);

    localparam int         W       = 4 * MAX_DIGITS;
    localparam logic [3:0] FULL    = 4'(MAX_DIGITS);
    localparam logic [3:0] MIN_LEN = 4'(MIN_DIGITS);
    localparam logic [3:0] M_LEN   = 4'(MASTER_LEN);

    // Only the low MASTER_LEN nibbles take part in the master comparison.
    function automatic logic [W-1:0] master_mask();
        logic [W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < unsigned'(MAX_DIGITS); i++) begin
            if (i < unsigned'(MASTER_LEN)) begin
                m[4*i +: 4] = '1;
            end
        end
        return m;
    endfunction

    localparam logic [W-1:0] MASK = master_mask();

    logic [W-1:0] mem_data;
    logic [W-1:0] buff_data;
    logic [3:0]   mem_len;
    logic [3:0]   buff_len;
    logic         digit_ok;

    assign digit_ok = (digit_i <= 4'd9);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_data  <= '0;
            mem_len   <= '0;
            buff_data <= '0;
            buff_len  <= '0;
        end else begin
            if (mem_rst_i) begin
                mem_data <= '0;
                mem_len  <= '0;
            end else if (mem_sl_i && digit_ok && (mem_len != FULL)) begin
                mem_data <= {mem_data[W-5:0], digit_i};
                mem_len  <= mem_len + 4'd1;
            end

            if (buff_rst_i) begin
                buff_data <= '0;
                buff_len  <= '0;
            end else if (buff_sl_i && digit_ok && (buff_len != FULL)) begin
                buff_data <= {buff_data[W-5:0], digit_i};
                buff_len  <= buff_len + 4'd1;
            end
        end
    end

    assign mem_limit_o   = (mem_len == FULL);
    assign buff_limit_o  = (buff_len == FULL);
    assign mem_len_o     = mem_len;
    assign buff_len_o    = buff_len;
    assign same_o        = (mem_len == buff_len) && (mem_len >= MIN_LEN) && (mem_data == buff_data);
    assign master_same_o = (buff_len == M_LEN) && ((buff_data & MASK) == (MASTER_CODE & MASK));

endmodule

// File: tb/tb_psw_store.sv
// Directed bench for psw_store: a reference model pushes expected outputs per cycle
// to a scoreboard queue, popped and compared after each clock edge.
module tb_psw_store;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit;
    logic       mem_rst, mem_sl, buff_rst, buff_sl;
    logic       same, master_same, mem_limit, buff_limit;
    logic [3:0] mem_len, buff_len;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       same;
        logic       master;
        logic       mem_lim;
        logic       buff_lim;
        logic [3:0] mem_len;
        logic [3:0] buff_len;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_mem_d, m_buff_d;
    logic [3:0]  m_mem_l, m_buff_l;

    psw_store #(
        .MAX_DIGITS (8),
        .MIN_DIGITS (4),
        .MASTER_LEN (8),
        .MASTER_CODE(32'h1234_5678)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .digit_i      (digit),
        .mem_rst_i    (mem_rst),
        .mem_sl_i     (mem_sl),
        .buff_rst_i   (buff_rst),
        .buff_sl_i    (buff_sl),
        .same_o       (same),
        .master_same_o(master_same),
        .mem_limit_o  (mem_limit),
        .buff_limit_o (buff_limit),
        .mem_len_o    (mem_len),
        .buff_len_o   (buff_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive commands, advance the model, push its prediction, then
    // pop and compare against the DUT just after the edge.
    task automatic cyc(input logic r, input logic mr, input logic ms,
                       input logic br, input logic bs, input logic [3:0] d);
        exp_t e;
        exp_t got;
        reset = r; mem_rst = mr; mem_sl = ms; buff_rst = br; buff_sl = bs; digit = d;
        if (r) begin
            m_mem_d = '0; m_mem_l = '0; m_buff_d = '0; m_buff_l = '0;
        end else begin
            if (mr) begin
                m_mem_d = '0; m_mem_l = '0;
            end else if (ms && d < 4'd10 && m_mem_l < 4'd8) begin
                m_mem_d = (m_mem_d << 4) | {28'd0, d};
                m_mem_l = m_mem_l + 4'd1;
            end
            if (br) begin
                m_buff_d = '0; m_buff_l = '0;
            end else if (bs && d < 4'd10 && m_buff_l < 4'd8) begin
                m_buff_d = (m_buff_d << 4) | {28'd0, d};
                m_buff_l = m_buff_l + 4'd1;
            end
        end
        e.same     = (m_mem_l == m_buff_l) && (m_mem_l >= 4'd4) && (m_mem_d == m_buff_d);
        e.master   = (m_buff_l == 4'd8) && (m_buff_d == 32'h1234_5678);
        e.mem_lim  = (m_mem_l == 4'd8);
        e.buff_lim = (m_buff_l == 4'd8);
        e.mem_len  = m_mem_l;
        e.buff_len = m_buff_l;
        sb.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0; mem_rst = 1'b0; mem_sl = 1'b0; buff_rst = 1'b0; buff_sl = 1'b0;
        got = sb.pop_front();
        check("same",       {3'd0, same},        {3'd0, got.same});
        check("master",     {3'd0, master_same}, {3'd0, got.master});
        check("mem_limit",  {3'd0, mem_limit},   {3'd0, got.mem_lim});
        check("buff_limit", {3'd0, buff_limit},  {3'd0, got.buff_lim});
        check("mem_len",    mem_len,             got.mem_len);
        check("buff_len",   buff_len,            got.buff_len);
    endtask

    task automatic mem_sh(input logic [3:0] d);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic buff_sh(input logic [3:0] d);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        reset = 1'b1; digit = '0;
        mem_rst = 1'b0; mem_sl = 1'b0; buff_rst = 1'b0; buff_sl = 1'b0;
        m_mem_d = '0; m_mem_l = '0; m_buff_d = '0; m_buff_l = '0;

        do_reset();
        do_reset();
        check("rst_same",     {3'd0, same},        4'd0);
        check("rst_master",   {3'd0, master_same}, 4'd0);
        check("rst_mem_lim",  {3'd0, mem_limit},   4'd0);
        check("rst_buff_lim", {3'd0, buff_limit},  4'd0);
        check("rst_mem_len",  mem_len,             4'd0);
        check("rst_buff_len", buff_len,            4'd0);

        // 1,2,3,4 in both stores, then one extra buffer digit
        for (int i = 1; i <= 4; i++) mem_sh(4'(i));
        for (int i = 1; i <= 4; i++) buff_sh(4'(i));
        check("same_1234",    {3'd0, same}, 4'd1);
        check("len_mem_1234", mem_len,      4'd4);
        check("len_buf_1234", buff_len,     4'd4);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
        check("same_hold",    {3'd0, same}, 4'd1);
        buff_sh(4'd5);
        check("same_extra",   {3'd0, same}, 4'd0);

        // below minimum length
        do_reset();
        for (int i = 1; i <= 3; i++) mem_sh(4'(i));
        for (int i = 1; i <= 3; i++) buff_sh(4'(i));
        check("same_short", {3'd0, same}, 4'd0);

        // memory saturation; buffer of eight 9s then proves the memory content
        do_reset();
        for (int i = 0; i < 9; i++) mem_sh(4'd9);
        check("sat_len",   mem_len,           4'd8);
        check("sat_limit", {3'd0, mem_limit}, 4'd1);
        for (int i = 0; i < 8; i++) buff_sh(4'd9);
        check("sat_data",  {3'd0, same},      4'd1);

        // master code, then rst+sl together on the buffer
        do_reset();
        for (int i = 1; i <= 8; i++) buff_sh(4'(i));
        check("master_hit",   {3'd0, master_same}, 4'd1);
        check("buff_full",    {3'd0, buff_limit},  4'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
        check("bprio_len",    buff_len,            4'd0);
        check("bprio_master", {3'd0, master_same}, 4'd0);

        // invalid digit, then reset mid-entry
        do_reset();
        mem_sh(4'd1);
        mem_sh(4'd2);
        mem_sh(4'hA);
        check("bad_digit", mem_len, 4'd2);
        mem_sh(4'hF);
        buff_sh(4'd1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd6);
        check("midrst_mem",  mem_len,  4'd0);
        check("midrst_buff", buff_len, 4'd0);
        check("midrst_same", {3'd0, same}, 4'd0);

        // simultaneous shifts into both stores
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
        check("sim_mem_len",  mem_len,  4'd1);
        check("sim_buff_len", buff_len, 4'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        check("sim_same", {3'd0, same}, 4'd1);

        // memory rst+sl priority, buffer unaffected
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
        check("mprio_len",  mem_len,  4'd0);
        check("mprio_buff", buff_len, 4'd4);
        check("mprio_same", {3'd0, same}, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
